tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Time-division demultiplexer. It takes one serial sample stream, where slot 0 of each frame is marked by a sync flag, and distributes the samples into NUM_CH parallel channel registers.
- It is the receive-side counterpart to our selector/mux blocks: mux merges channels onto one line, tdm_demux splits them back out.
- It sits between a serial link front-end and per-channel processing. Outputs update atomically once per complete frame.

Parameters:
- NUM_CH, 4, number of channels (time slots) per frame; legal range 2..16.
- DATA_W, 8, width of one sample in bits.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_sync are valid this cycle; no backpressure.
- in_data  input  DATA_W  serial sample.
- in_sync  input  1  qualified by in_valid; marks slot 0 of a frame.
- out_data  output  NUM_CH*DATA_W  channel k in bits [k*DATA_W +: DATA_W], registered.
- out_frame_valid  output  1  one-cycle pulse: out_data just updated with a complete frame.
- sync_err  output  1  one-cycle pulse: framing violation detected.
- locked  output  1  high while the FSM is in LOCKED.

Behaviour:
- Reset: rst_n low asynchronously clears out_data=0, out_frame_valid=0, sync_err=0, locked=0, slot counter=0, all shadow registers=0, and sets the FSM to HUNT. Reset asserted mid-frame discards the partial frame.
- Storage:
  - Internal shadow registers shadow[0..NUM_CH-1].
  - Slot counter width is clog2(NUM_CH).
  - Samples are written into shadow, never directly into out_data.
- in_valid low: no state change; the counter holds and the pulses are 0.
- FSM HUNT (locked=0):
  - Valid sample with in_sync=0: dropped, no error.
  - Valid sample with in_sync=1: shadow[0]<=in_data, slot<=1, go to LOCKED.
- FSM LOCKED (locked=1), valid sample at slot s:
  - s==0, in_sync=1: shadow[0]<=in_data, slot<=1.
  - s==0, in_sync=0: lost alignment. Sample dropped, sync_err pulses next cycle, go to HUNT, slot<=0.
  - 0<s<NUM_CH-1, in_sync=0: shadow[s]<=in_data, slot<=s+1.
  - s==NUM_CH-1, in_sync=0: frame complete.
    - Next edge: out_data loads shadow[0..NUM_CH-2] plus in_data as channel NUM_CH-1.
    - out_frame_valid=1 for exactly one cycle.
    - slot wraps to 0.
  - s!=0, in_sync=1: early sync.
    - sync_err pulses, partial frame discarded, out_data unchanged.
    - The sample is taken as the new slot 0: shadow[0]<=in_data, slot<=1.
    - FSM stays LOCKED.
- Latency: out_data and out_frame_valid change on the clock edge that accepts the last slot sample. They are visible in the cycle after the sample is presented.
- out_data holds its value between frames; it is never partially updated.
- The sync_err and out_frame_valid pulses are registered and never asserted together. An early sync on the last slot is an error, not a completion.
- Back-to-back valid samples every cycle are supported at full throughput. Idle gaps of any length between samples are allowed without losing lock.

Test Plan:
- Reset then lock: NUM_CH=4, DATA_W=8. Send samples 0x11(sync), 0x22, 0x33, 0x44 on consecutive cycles -> locked=1 after the first sample; one cycle after 0x44, out_frame_valid=1 and out_data=0x44332211; sync_err stays 0.
- Hunt discard: send 0xAA, 0xBB with in_sync=0 before any sync, then a full frame 0x01(sync), 0x02, 0x03, 0x04 -> 0xAA/0xBB ignored, locked rises on 0x01, out_data=0x04030201, no sync_err.
- Gaps and back-to-back: run two frames with random in_valid gaps (0-3 cycles), then two frames with no gaps -> out_frame_valid pulses once per frame, and each out_data matches its frame.
- Early sync: locked, send 0x10(sync), 0x20, then 0x30 with in_sync=1, then 0x40, 0x50, 0x60 -> sync_err pulses once, no frame is output for 0x10/0x20, and the next output is out_data=0x60504030.
- Missing sync: after a complete frame, send 0x99 with in_sync=0 at slot 0 -> sync_err pulses, locked=0, out_data holds its previous value; a following sync re-locks.
- Async reset mid-frame: after 2 of 4 samples, pulse rst_n low between clock edges -> outputs clear immediately, locked=0; a new frame after release is output correctly with no residue from the old frame.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: receive-side time-division demultiplexer.
// A serial sample stream is split into NUM_CH channel registers.
// Slot 0 of each frame is marked by in_sync.
// Samples collect in shadow registers, and out_data is loaded in one step
// only when a complete frame has arrived.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sync,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_frame_valid,
    output logic                     sync_err,
    output logic                     locked
);

    localparam int SLOT_W = $clog2(NUM_CH);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                    state_q;
    logic [SLOT_W-1:0]         slot_q;
    logic [DATA_W-1:0]         shadow_q [NUM_CH];
    logic [NUM_CH*DATA_W-1:0]  out_data_q;
    logic [NUM_CH*DATA_W-1:0]  frame_d;
    logic                      frame_vld_q;
    logic                      sync_err_q;

    // Assemble the completed frame: the shadow registers, with the sample
    // arriving now taking the place of the last channel.
    always_comb begin
        frame_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == NUM_CH - 1) begin
                frame_d[k*DATA_W +: DATA_W] = in_data;
            end else begin
                frame_d[k*DATA_W +: DATA_W] = shadow_q[k];
            end
        end
    end

    // Framing FSM: hunt for sync, then track slots and publish whole frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            out_data_q  <= '0;
            frame_vld_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted below.
            frame_vld_q <= 1'b0;
            sync_err_q  <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        // Samples arriving without sync are dropped silently.
                        if (in_sync) begin
                            shadow_q[0] <= in_data;
                            slot_q      <= SLOT_W'(1);
                            state_q     <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (in_sync) begin
                            // A sync restarts the frame.
                            // A sync at any slot other than 0 is an early sync:
                            // the partial frame is abandoned and an error is flagged.
                            shadow_q[0] <= in_data;
                            slot_q      <= SLOT_W'(1);
                            if (slot_q != '0) begin
                                sync_err_q <= 1'b1;
                            end
                        end else if (slot_q == '0) begin
                            // A sync was expected here, so alignment is lost.
                            sync_err_q <= 1'b1;
                            slot_q     <= '0;
                            state_q    <= HUNT;
                        end else if (slot_q == LAST_SLOT) begin
                            shadow_q[slot_q] <= in_data;
                            out_data_q       <= frame_d;
                            frame_vld_q      <= 1'b1;
                            slot_q           <= '0;
                        end else begin
                            shadow_q[slot_q] <= in_data;
                            slot_q           <= slot_q + SLOT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        slot_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign out_data        = out_data_q;
    assign out_frame_valid = frame_vld_q;
    assign sync_err        = sync_err_q;
    assign locked          = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed test of tdm_demux with NUM_CH=4 and DATA_W=8.
module tb_tdm_demux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     in_sync = 1'b0;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     out_frame_valid;
    logic                     sync_err;
    logic                     locked;

    int n_tot = 0;
    int n_bad = 0;
    int fv_cnt = 0;
    int err_cnt = 0;

    tdm_demux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_sync         (in_sync),
        .out_data        (out_data),
        .out_frame_valid (out_frame_valid),
        .sync_err        (sync_err),
        .locked          (locked)
    );

    always #5 clk = ~clk;

    // Count the status pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            fv_cnt  += int'(out_frame_valid);
            err_cnt += int'(sync_err);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sync  = s;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < NUM_CH; i++) begin
            if (maxgap > 0) begin
                int g;
                g = $urandom_range(maxgap, 0);
                for (int j = 0; j < g; j++) idle();
            end
            send(w[i*8 +: 8], (i == 0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] fr [4];
        fr[0] = 32'hA4A3A2A1;
        fr[1] = 32'hB4B3B2B1;
        fr[2] = 32'hC4C3C2C1;
        fr[3] = 32'hD4D3D2D1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_locked", 64'(locked), 64'h0);
        chk("rst_fv", 64'(out_frame_valid), 64'h0);
        chk("rst_err", 64'(sync_err), 64'h0);
        rst_n = 1'b1;

        // Reset then lock
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        chk("lock_after_first", 64'(locked), 64'h1);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("no_fv_before_last", 64'(out_frame_valid), 64'h0);
        idle();
        chk("t1_fv", 64'(out_frame_valid), 64'h1);
        chk("t1_data", 64'(out_data), 64'h44332211);
        chk("t1_err", 64'(sync_err), 64'h0);
        idle();
        chk("t1_fv_one_cycle", 64'(out_frame_valid), 64'h0);
        chk("t1_data_hold", 64'(out_data), 64'h44332211);
        chk("t1_err_cnt", 64'(err_cnt), 64'h0);

        // Hunt discard
        do_reset();
        fv_cnt = 0; err_cnt = 0;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        idle();
        chk("hunt_unlocked", 64'(locked), 64'h0);
        send_frame(32'h04030201, 0);
        idle();
        chk("hunt_data", 64'(out_data), 64'h04030201);
        chk("hunt_locked", 64'(locked), 64'h1);
        idle();
        chk("hunt_fv_cnt", 64'(fv_cnt), 64'h1);
        chk("hunt_err_cnt", 64'(err_cnt), 64'h0);

        // Gaps, then back-to-back
        fv_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            send_frame(fr[f], 3);
            idle();
            chk("gap_fv", 64'(out_frame_valid), 64'h1);
            chk("gap_data", 64'(out_data), 64'(fr[f]));
            chk("gap_locked", 64'(locked), 64'h1);
        end
        send_frame(fr[2], 0);
        send(fr[3][7:0], 1'b1);
        chk("b2b_fv0", 64'(out_frame_valid), 64'h1);
        chk("b2b_data0", 64'(out_data), 64'(fr[2]));
        send(fr[3][15:8], 1'b0);
        send(fr[3][23:16], 1'b0);
        send(fr[3][31:24], 1'b0);
        idle();
        chk("b2b_fv1", 64'(out_frame_valid), 64'h1);
        chk("b2b_data1", 64'(out_data), 64'(fr[3]));
        idle();
        chk("gap_fv_cnt", 64'(fv_cnt), 64'h4);
        chk("gap_err_cnt", 64'(err_cnt), 64'h0);

        // Early sync mid-frame
        fv_cnt = 0; err_cnt = 0;
        send(8'h10, 1'b1);
        send(8'h20, 1'b0);
        send(8'h30, 1'b1);
        send(8'h40, 1'b0);
        chk("early_err", 64'(sync_err), 64'h1);
        chk("early_no_fv", 64'(out_frame_valid), 64'h0);
        chk("early_data_hold", 64'(out_data), 64'(fr[3]));
        chk("early_locked", 64'(locked), 64'h1);
        send(8'h50, 1'b0);
        send(8'h60, 1'b0);
        idle();
        chk("early_fv", 64'(out_frame_valid), 64'h1);
        chk("early_data", 64'(out_data), 64'h60504030);
        idle();
        chk("early_err_cnt", 64'(err_cnt), 64'h1);
        chk("early_fv_cnt", 64'(fv_cnt), 64'h1);

        // Early sync on the last slot is an error, not a completion
        fv_cnt = 0; err_cnt = 0;
        send(8'h21, 1'b1);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b1);
        send(8'h25, 1'b0);
        chk("last_early_err", 64'(sync_err), 64'h1);
        chk("last_early_no_fv", 64'(out_frame_valid), 64'h0);
        chk("last_early_hold", 64'(out_data), 64'h60504030);
        send(8'h26, 1'b0);
        send(8'h27, 1'b0);
        idle();
        chk("last_early_data", 64'(out_data), 64'h27262524);
        idle();
        chk("last_early_fv_cnt", 64'(fv_cnt), 64'h1);
        chk("last_early_err_cnt", 64'(err_cnt), 64'h1);

        // Missing sync at slot 0
        err_cnt = 0;
        send(8'h99, 1'b0);
        idle();
        chk("miss_err", 64'(sync_err), 64'h1);
        chk("miss_unlocked", 64'(locked), 64'h0);
        chk("miss_hold", 64'(out_data), 64'h27262524);
        send_frame(32'h0D0C0B0A, 0);
        idle();
        chk("relock_data", 64'(out_data), 64'h0D0C0B0A);
        chk("relock_locked", 64'(locked), 64'h1);
        idle();
        chk("miss_err_cnt", 64'(err_cnt), 64'h1);

        // Asynchronous reset mid-frame
        send(8'h55, 1'b1);
        send(8'h66, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sync = 1'b0;
        #1;
        chk("arst_data", 64'(out_data), 64'h0);
        chk("arst_locked", 64'(locked), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fv_cnt = 0; err_cnt = 0;
        send(8'h77, 1'b0);
        send_frame(32'h7B7A7978, 0);
        idle();
        chk("arst_new_data", 64'(out_data), 64'h7B7A7978);
        chk("arst_new_fv", 64'(out_frame_valid), 64'h1);
        idle();
        chk("arst_fv_cnt", 64'(fv_cnt), 64'h1);
        chk("arst_err_cnt", 64'(err_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
